writeback_arbiter: RTL and testbench



---
 rtl/writeback_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Purpose: takes finished results from the three execute-stage functional units
// and puts them onto the one register-file write port. Index 0 is the arithmetic
// unit (AU), 1 is the multiply unit (MU) and 2 is the load-store unit (LSU).
// Each source has its own small result FIFO. A unit therefore stalls only when
// its own FIFO is full. Each cycle one non-empty FIFO is granted, and its head
// entry is registered onto wen/w_sel/w_data.
//
// Build option:
//   WB_ARB_RR_EN  defined   -> round-robin arbitration. The search starts one
//                              past the last granted source.
//                 undefined -> fixed priority LSU > MU > AU. No last-grant
//                              register is built.
//
// Parameters:
//   FIFO_DEPTH   entries per source FIFO. Must be a power of two and >= 2.
//
// Ports:
//   CLK                      core clock; all state changes on the rising edge
//   RST                      asynchronous, active-high reset
//   flush                    synchronous flush; drops every buffered result
//   au/mu/lsu_valid          the source presents a result
//   au/mu/lsu_rd   [4:0]     destination register (rd == 0 is accepted, then dropped)
//   au/mu/lsu_wdata[31:0]    result data
//   au/mu/lsu_ready          the source FIFO has room (depends on state only)
//   wen                      register-file write enable (registered)
//   w_sel          [4:0]     register-file write index (registered)
//   w_data         [31:0]    register-file write data (registered)
//   busy                     some FIFO is non-empty, or a write is being presented
// ---------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        au_valid,
    input  logic [4:0]  au_rd,
    input  logic [31:0] au_wdata,
    output logic        au_ready,
    input  logic        mu_valid,
    input  logic [4:0]  mu_rd,
    input  logic [31:0] mu_wdata,
    output logic        mu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        wen,
    output logic [4:0]  w_sel,
    output logic [31:0] w_data,
    output logic        busy
);

    localparam int NSRC    = 3;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 5 + 32;

    // Source-indexed views of the three result interfaces.
    logic [NSRC-1:0] src_valid;
    logic [4:0]      src_rd   [NSRC];
    logic [31:0]     src_data [NSRC];

    assign src_valid   = {lsu_valid, mu_valid, au_valid};
    assign src_rd[0]   = au_rd;
    assign src_rd[1]   = mu_rd;
    assign src_rd[2]   = lsu_rd;
    assign src_data[0] = au_wdata;
    assign src_data[1] = mu_wdata;
    assign src_data[2] = lsu_wdata;

    // FIFO storage and bookkeeping.
    logic [ENTRY_W-1:0] mem    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr [NSRC];
    logic [PTR_W-1:0]   wr_ptr [NSRC];
    logic [CNT_W-1:0]   count  [NSRC];

    logic [NSRC-1:0]    ready;
    logic [NSRC-1:0]    not_empty;
    logic [NSRC-1:0]    push;
    logic [NSRC-1:0]    grant;
    logic [1:0]         grant_idx;
    logic [ENTRY_W-1:0] head_entry;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ready[i]     = (count[i] < CNT_W'(FIFO_DEPTH));
            not_empty[i] = (count[i] != '0);
            // A write to x0 completes the handshake but is never stored.
            push[i]      = src_valid[i] & ready[i] & (src_rd[i] != 5'd0);
        end
    end

    assign au_ready  = ready[0];
    assign mu_ready  = ready[1];
    assign lsu_ready = ready[2];

    assign busy = (|not_empty) | wen;

`ifdef WB_ARB_RR_EN
    // Round-robin arbitration. last_grant changes only on a real grant, so an
    // idle cycle does not rotate priority.
    logic [1:0] last_grant;
    logic [1:0] cand;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // NOTE: every variable written in a combinational block gets a default
    // value before any conditional assignment, so no latch is inferred.
    always_comb begin
        grant = '0;
        cand  = next_src(last_grant);
        for (int k = 0; k < NSRC; k++) begin
            if (grant == '0 && not_empty[cand]) begin
                grant[cand] = 1'b1;
            end
            cand = next_src(cand);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 2'd2;
        end else if (!flush && (|grant)) begin
            last_grant <= grant_idx;
        end
    end
`else
    // Fixed priority. Loads go first so the load-store unit is freed early.
    always_comb begin
        grant = '0;
        if (not_empty[2]) begin
            grant[2] = 1'b1;
        end else if (not_empty[1]) begin
            grant[1] = 1'b1;
        end else if (not_empty[0]) begin
            grant[0] = 1'b1;
        end
    end
`endif

    always_comb begin
        grant_idx = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            if (grant[k]) begin
                grant_idx = 2'(k);
            end
        end
    end

    assign head_entry = mem[grant_idx][rd_ptr[grant_idx]];

    // NOTE: the storage array has no reset. Pointers and counts decide which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NSRC; i++) begin
            if (!flush && push[i]) begin
                mem[i][wr_ptr[i]] <= {src_rd[i], src_data[i]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge, which keeps the
    // FIFO bookkeeping and the output stage consistent with each other.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            wen    <= 1'b0;
            w_sel  <= 5'd0;
            w_data <= 32'd0;
        end else if (flush) begin
            // Flush overrides push and grant. w_sel/w_data keep their values
            // because wen is dropped.
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            wen <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (grant[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], grant[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: ;
                endcase
            end
            wen <= |grant;
            if (|grant) begin
                {w_sel, w_data} <= head_entry;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Self-checking bench for writeback_arbiter with FIFO_DEPTH = 2. Each stimulus
// block pushes its hand-computed register-file writes ({w_sel, w_data}) into
// exp_q. A monitor samples on the falling edge. Whenever wen is high it pops
// exp_q and compares. Cycle-exact properties (reset values, latency, back-to-back
// writes, readiness, flush, asynchronous reset) are checked inline, 1 time unit
// after the rising edge. Expected orders follow WB_ARB_RR_EN the same way the
// design does.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        au_valid = 1'b0, mu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  au_rd = '0, mu_rd = '0, lsu_rd = '0;
    logic [31:0] au_wdata = '0, mu_wdata = '0, lsu_wdata = '0;
    logic        au_ready, mu_ready, lsu_ready;
    logic        wen;
    logic [4:0]  w_sel;
    logic [31:0] w_data;
    logic        busy;

    always #5 CLK = ~CLK;

    writeback_arbiter #(.FIFO_DEPTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .au_valid  (au_valid),
        .au_rd     (au_rd),
        .au_wdata  (au_wdata),
        .au_ready  (au_ready),
        .mu_valid  (mu_valid),
        .mu_rd     (mu_rd),
        .mu_wdata  (mu_wdata),
        .mu_ready  (mu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_wdata (lsu_wdata),
        .lsu_ready (lsu_ready),
        .wen       (wen),
        .w_sel     (w_sel),
        .w_data    (w_data),
        .busy      (busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got w_sel=%0d w_data=%h, required no write",
                         w_sel, w_data);
            end else begin
                check("write", {27'd0, w_sel, w_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // Safety net: the bench must always stop on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        flush     = 1'b0;
        au_valid  = 1'b0;
        mu_valid  = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s_drain: %0d writes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        int a_n;
        int l_n;
        logic au_hs;
        logic lsu_hs;

        // ---------------- Test 1: reset state, single AU write ----------------
        #3;
        check("rst_wen",    wen,    1'b0);
        check("rst_w_sel",  w_sel,  5'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_ready",  {au_ready, mu_ready, lsu_ready}, 3'b111);
        check("rst_busy",   busy,   1'b0);
        tick();
        RST = 1'b0;
        tick();
        check("post_rst_ready", {au_ready, mu_ready, lsu_ready}, 3'b111);
        check("post_rst_busy",  busy, 1'b0);

        au_valid = 1'b1; au_rd = 5'd5; au_wdata = 32'hDEAD_BEEF;
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        tick();                                   // E1: push
        drive_idle();
        check("t1_wen_e1",  wen,  1'b0);
        check("t1_busy_e1", busy, 1'b1);
        tick();                                   // E2: write presented
        check("t1_wen_e2",  wen,  1'b1);
        tick();
        check("t1_wen_e3",  wen,  1'b0);
        check("t1_busy_e3", busy, 1'b0);
        wait_drain("t1", 10);

        // ---------------- Test 2: three simultaneous pushes ----------------
        do_reset();
        au_valid  = 1'b1; au_rd  = 5'd1; au_wdata  = 32'h1111_1111;
        mu_valid  = 1'b1; mu_rd  = 5'd2; mu_wdata  = 32'h2222_2222;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'h3333_3333;
`ifdef WB_ARB_RR_EN
        exp_q.push_back({5'd1, 32'h1111_1111});
        exp_q.push_back({5'd2, 32'h2222_2222});
        exp_q.push_back({5'd3, 32'h3333_3333});
`else
        exp_q.push_back({5'd3, 32'h3333_3333});
        exp_q.push_back({5'd2, 32'h2222_2222});
        exp_q.push_back({5'd1, 32'h1111_1111});
`endif
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t2_back_to_back_wen", wen, 1'b1);
        end
        tick();
        check("t2_wen_done",  wen,  1'b0);
        check("t2_busy_done", busy, 1'b0);
        wait_drain("t2", 10);

        // ---------------- Test 3: LSU held valid, AU contending ----------------
        do_reset();
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back({5'(k), 32'hA000_0000 | 32'(k)});
            exp_q.push_back({5'(16 + k), 32'hC000_0000 | 32'(k)});
        end
`else
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back({5'(16 + k), 32'hC000_0000 | 32'(k)});
        end
        exp_q.push_back({5'd1, 32'hA000_0001});
        exp_q.push_back({5'd2, 32'hA000_0002});
`endif
        a_n = 0;
        l_n = 0;
        for (int c = 0; c < 10; c++) begin
            au_valid  = 1'b1;
            au_rd     = 5'(a_n + 1);
            au_wdata  = 32'hA000_0000 | 32'(a_n + 1);
            lsu_valid = 1'b1;
            lsu_rd    = 5'(16 + l_n + 1);
            lsu_wdata = 32'hC000_0000 | 32'(l_n + 1);
`ifdef WB_ARB_RR_EN
            if (c == 2) check("t3_au_ready_c2", au_ready, 1'b1);
            if (c == 3) check("t3_au_ready_c3", au_ready, 1'b0);
`else
            if (c == 2) check("t3_au_ready_c2", au_ready, 1'b0);
            if (c == 9) check("t3_au_starved", au_ready, 1'b0);
`endif
            au_hs  = au_ready;
            lsu_hs = lsu_ready;
            tick();
            if (au_hs)  a_n++;
            if (lsu_hs) l_n++;
        end
        drive_idle();
        wait_drain("t3", 40);
`ifdef WB_ARB_RR_EN
        check("t3_au_accepted",  32'(a_n), 32'd6);
        check("t3_lsu_accepted", 32'(l_n), 32'd6);
`else
        check("t3_au_accepted",  32'(a_n), 32'd2);
        check("t3_lsu_accepted", 32'(l_n), 32'd10);
`endif

        // ---------------- Test 4: rd = 0 write is dropped ----------------
        do_reset();
        au_valid = 1'b1; au_rd = 5'd0; au_wdata = 32'h0000_1234;
        check("t4_handshake_ready", au_ready, 1'b1);
        tick();
        drive_idle();
        check("t4_busy_e1", busy, 1'b0);
        tick();
        check("t4_wen_e2",  wen,  1'b0);
        check("t4_busy_e2", busy, 1'b0);
        wait_drain("t4", 5);

        // ---------------- Test 5: flush with a concurrent push ----------------
        do_reset();
        au_valid  = 1'b1; au_rd  = 5'd1; au_wdata  = 32'h5000_0001;
        mu_valid  = 1'b1; mu_rd  = 5'd2; mu_wdata  = 32'h5000_0002;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'h5000_0003;
        tick();                                   // E1: three pushes
        au_rd  = 5'd4; au_wdata  = 32'h5000_0004;
        mu_rd  = 5'd5; mu_wdata  = 32'h5000_0005;
        lsu_rd = 5'd6; lsu_wdata = 32'h5000_0006;
`ifdef WB_ARB_RR_EN
        exp_q.push_back({5'd1, 32'h5000_0001});
`else
        exp_q.push_back({5'd3, 32'h5000_0003});
`endif
        tick();                                   // E2: pushes plus first grant
        drive_idle();
        flush = 1'b1;
        au_valid = 1'b1; au_rd = 5'd9; au_wdata = 32'h9999_9999;
        tick();                                   // E3: flush
        drive_idle();
        check("t5_wen",   wen,  1'b0);
        check("t5_ready", {au_ready, mu_ready, lsu_ready}, 3'b111);
        check("t5_busy",  busy, 1'b0);
        repeat (3) tick();
        check("t5_wen_later", wen, 1'b0);
        wait_drain("t5", 5);

        // ---------------- Test 6: asynchronous reset during a write ----------------
        do_reset();
        au_valid = 1'b1; au_rd = 5'd7; au_wdata = 32'h7777_7777;
        mu_valid = 1'b1; mu_rd = 5'd8; mu_wdata = 32'h8888_8888;
        tick();                                   // E1
        drive_idle();
        tick();                                   // E2: first write presented
        check("t6_wen_before_rst", wen, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("t6_rst_wen",    wen,    1'b0);
        check("t6_rst_w_sel",  w_sel,  5'd0);
        check("t6_rst_w_data", w_data, 32'd0);
        check("t6_rst_busy",   busy,   1'b0);
        tick();
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t6_no_write_after_rst", wen, 1'b0);
        end
        wait_drain("t6", 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
